// File: rtl/sram_pkg.sv
// Shared types and helpers for the masked 1R1W SRAM model.
// Optional feature macro: SRAM_PARITY_EN (per-granule even parity).
package sram_pkg;

   typedef enum logic {
      CLEAR,
      READY
   } clr_state_e;

   // Widest granule the parity helper accepts; narrower granules are zero-extended.
   localparam int unsigned PAR_MAXW = 1024;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = (v > 0) ? v - 1 : 0;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

   // Even parity of one granule (XOR reduction).
   function automatic logic gran_parity(input logic [PAR_MAXW-1:0] g);
      return ^g;
   endfunction

   // Legal geometry: at least two entries, granule divides the word.
   function automatic bit cfg_ok(input int unsigned depth,
                                 input int unsigned width,
                                 input int unsigned gran);
      return (depth >= 2) && (gran > 0) && (gran <= PAR_MAXW) && ((width % gran) == 0);
   endfunction

endpackage

// File: rtl/sram_clear_ctrl.sv
// Post-reset clear sequencer: zeroes every entry once, then reports init_done.
module sram_clear_ctrl
   import sram_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic          clock,
   input  logic          reset,
   output logic          clear_we,
   output logic [AW-1:0] clear_addr,
   output logic          init_done
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   clr_state_e    state, state_nx;
   logic [AW-1:0] cnt, cnt_nx;

   // State and counter registers; reset restarts the clear from entry 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state logic and clear-port drive.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      clear_we   = 1'b0;
      clear_addr = cnt;
      init_done  = (state == READY);
      case (state)
         CLEAR: begin
            clear_we = 1'b1;
            if (cnt == LAST) begin
               state_nx = READY;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         READY: begin
            state_nx = READY;
         end
         default: begin
            state_nx = CLEAR;
         end
      endcase
   end

endmodule

// File: rtl/sram_1r1w_masked.sv
// Parametrised 1-read/1-write SRAM with per-granule write mask, registered
// held read data, optional read-during-write forwarding and post-reset clear.
// Optional feature macro: SRAM_PARITY_EN (stored even parity per granule).
module sram_1r1w_masked
   import sram_pkg::*;
#(
   parameter  int unsigned DEPTH     = 8,
   parameter  int unsigned WIDTH     = 247,
   parameter  int unsigned MASK_GRAN = 247,
   parameter  int unsigned BYPASS    = 1,
   localparam int unsigned AW        = clog2(DEPTH),
   localparam int unsigned NGRAN     = WIDTH / MASK_GRAN
) (
   input  logic             clock,
   input  logic             reset,
   output logic             init_done,
   input  logic             R0_en,
   input  logic [AW-1:0]    R0_addr,
   output logic [WIDTH-1:0] R0_data,
   output logic [NGRAN-1:0] R0_err,
   input  logic             W0_en,
   input  logic [AW-1:0]    W0_addr,
   input  logic [NGRAN-1:0] W0_mask,
   input  logic [WIDTH-1:0] W0_data
);

   generate
      if (!cfg_ok(DEPTH, WIDTH, MASK_GRAN)) begin : g_cfg_err
         $error("sram_1r1w_masked: illegal DEPTH/WIDTH/MASK_GRAN combination");
      end
   endgenerate

   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   logic             clear_we;
   logic [AW-1:0]    clear_addr;
   logic             port_ok;
   logic             w_ok;
   logic             r_in_range;
   logic [WIDTH-1:0] rd_data_nx;
   logic [NGRAN-1:0] rd_err_nx;

   logic [WIDTH-1:0] ram [DEPTH];

`ifdef SRAM_PARITY_EN
   logic [NGRAN-1:0] par [DEPTH];

   function automatic logic par_of(input logic [MASK_GRAN-1:0] g);
      logic [PAR_MAXW-1:0] t;
      t = '0;
      t[MASK_GRAN-1:0] = g;
      return gran_parity(t);
   endfunction
`endif

   sram_clear_ctrl #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clear (
      .clock      (clock),
      .reset      (reset),
      .clear_we   (clear_we),
      .clear_addr (clear_addr),
      .init_done  (init_done)
   );

   assign port_ok    = init_done & ~reset;
   assign w_ok       = port_ok & W0_en & ({1'b0, W0_addr} < DEPTH_W);
   assign r_in_range = ({1'b0, R0_addr} < DEPTH_W);

   // Array update: clear sequencer owns the write port until init completes.
   always_ff @(posedge clock) begin
      if (clear_we) begin
         ram[clear_addr] <= '0;
`ifdef SRAM_PARITY_EN
         par[clear_addr] <= '0;
`endif
      end else if (w_ok) begin
         for (int unsigned g = 0; g < NGRAN; g++) begin
            if (W0_mask[g]) begin
               ram[W0_addr][g*MASK_GRAN +: MASK_GRAN] <= W0_data[g*MASK_GRAN +: MASK_GRAN];
`ifdef SRAM_PARITY_EN
               par[W0_addr][g] <= par_of(W0_data[g*MASK_GRAN +: MASK_GRAN]);
`endif
            end
         end
      end
   end

   // Read value for the next edge: array word, error check, then forwarding.
   always_comb begin
      rd_data_nx = '0;
      rd_err_nx  = '0;
      if (r_in_range) begin
         rd_data_nx = ram[R0_addr];
`ifdef SRAM_PARITY_EN
         for (int unsigned g = 0; g < NGRAN; g++) begin
            rd_err_nx[g] = par[R0_addr][g] ^ par_of(rd_data_nx[g*MASK_GRAN +: MASK_GRAN]);
         end
`endif
         // Forwarded granules carry freshly computed parity, so they never flag.
         if ((BYPASS != 0) && w_ok && (W0_addr == R0_addr)) begin
            for (int unsigned g = 0; g < NGRAN; g++) begin
               if (W0_mask[g]) begin
                  rd_data_nx[g*MASK_GRAN +: MASK_GRAN] = W0_data[g*MASK_GRAN +: MASK_GRAN];
                  rd_err_nx[g] = 1'b0;
               end
            end
         end
      end
   end

   // Output register: loads on an accepted read, otherwise holds.
   always_ff @(posedge clock) begin
      if (reset) begin
         R0_data <= '0;
         R0_err  <= '0;
      end else if (port_ok && R0_en) begin
         R0_data <= rd_data_nx;
         R0_err  <= rd_err_nx;
      end
   end

endmodule

// File: tb/tb_sram_1r1w_masked.sv
// Directed bench for sram_1r1w_masked: one forwarding and one non-forwarding
// instance share all stimulus. SRAM_PARITY_EN enables the parity-poke case.
module tb_sram_1r1w_masked;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        R0_en = 1'b0;
   logic [2:0]  R0_addr = '0;
   logic        W0_en = 1'b0;
   logic [2:0]  W0_addr = '0;
   logic [3:0]  W0_mask = '0;
   logic [31:0] W0_data = '0;

   logic        done1, done0;
   logic [31:0] rdata1, rdata0;
   logic [3:0]  err1, err0;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clock = ~clock;

   sram_1r1w_masked #(
      .DEPTH     (8),
      .WIDTH     (32),
      .MASK_GRAN (8),
      .BYPASS    (1)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .init_done (done1),
      .R0_en     (R0_en),
      .R0_addr   (R0_addr),
      .R0_data   (rdata1),
      .R0_err    (err1),
      .W0_en     (W0_en),
      .W0_addr   (W0_addr),
      .W0_mask   (W0_mask),
      .W0_data   (W0_data)
   );

   sram_1r1w_masked #(
      .DEPTH     (8),
      .WIDTH     (32),
      .MASK_GRAN (8),
      .BYPASS    (0)
   ) dut0 (
      .clock     (clock),
      .reset     (reset),
      .init_done (done0),
      .R0_en     (R0_en),
      .R0_addr   (R0_addr),
      .R0_data   (rdata0),
      .R0_err    (err0),
      .W0_en     (W0_en),
      .W0_addr   (W0_addr),
      .W0_mask   (W0_mask),
      .W0_data   (W0_data)
   );

   typedef struct {
      logic        r_en;
      logic [2:0]  r_addr;
      logic        w_en;
      logic [2:0]  w_addr;
      logic [3:0]  w_mask;
      logic [31:0] w_data;
      logic [31:0] exp1;
      logic [31:0] exp0;
   } vec_t;

   localparam int NVEC = 22;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic re, input logic [2:0] ra,
                               input logic we, input logic [2:0] wa,
                               input logic [3:0] wm, input logic [31:0] wd,
                               input logic [31:0] e1, input logic [31:0] e0);
      vec_t v;
      v.r_en = re; v.r_addr = ra; v.w_en = we; v.w_addr = wa;
      v.w_mask = wm; v.w_data = wd; v.exp1 = e1; v.exp0 = e0;
      return v;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_ports();
      R0_en = 1'b0; W0_en = 1'b0; W0_mask = '0; W0_data = '0;
   endtask

   task automatic wait_init(output int unsigned cyc);
      cyc = 0;
      while (!done1 && cyc < 20) begin
         step();
         cyc++;
      end
   endtask

   task automatic read_chk(input logic [2:0] a, input logic [31:0] e, input string tag);
      idle_ports();
      R0_en = 1'b1; R0_addr = a;
      step();
      chk($sformatf("%s_rd%0d_b1", tag, a), rdata1, e);
      chk($sformatf("%s_rd%0d_b0", tag, a), rdata0, e);
      R0_en = 1'b0;
   endtask

   initial begin
      int unsigned cyc;

      for (int i = 0; i < 8; i++)
         vecs[i] = mk(1'b1, 3'(i), 1'b0, 3'd0, 4'h0, 32'h0, 32'h0, 32'h0);
      vecs[8]  = mk(1'b0, 3'd0, 1'b1, 3'd3, 4'hF, 32'hAABBCCDD, 32'h0, 32'h0);
      vecs[9]  = mk(1'b0, 3'd0, 1'b1, 3'd3, 4'h5, 32'h11223344, 32'h0, 32'h0);
      vecs[10] = mk(1'b1, 3'd3, 1'b0, 3'd0, 4'h0, 32'h0, 32'hAA22CC44, 32'hAA22CC44);
      vecs[11] = mk(1'b1, 3'd5, 1'b1, 3'd5, 4'h3, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0);
      vecs[12] = mk(1'b1, 3'd5, 1'b0, 3'd0, 4'h0, 32'h0, 32'h0000FFFF, 32'h0000FFFF);
      vecs[13] = mk(1'b1, 3'd3, 1'b1, 3'd2, 4'hF, 32'h12345678, 32'hAA22CC44, 32'hAA22CC44);
      vecs[14] = mk(1'b1, 3'd2, 1'b0, 3'd0, 4'h0, 32'h0, 32'h12345678, 32'h12345678);
      vecs[15] = mk(1'b0, 3'd2, 1'b1, 3'd2, 4'hF, 32'hDEADBEEF, 32'h12345678, 32'h12345678);
      vecs[16] = mk(1'b0, 3'd2, 1'b0, 3'd0, 4'h0, 32'h0, 32'h12345678, 32'h12345678);
      vecs[17] = mk(1'b1, 3'd2, 1'b0, 3'd0, 4'h0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF);
      vecs[18] = mk(1'b1, 3'd4, 1'b1, 3'd4, 4'h0, 32'hFFFFFFFF, 32'h0, 32'h0);
      vecs[19] = mk(1'b1, 3'd4, 1'b0, 3'd0, 4'h0, 32'h0, 32'h0, 32'h0);
      vecs[20] = mk(1'b1, 3'd3, 1'b1, 3'd6, 4'hF, 32'h0F0F0F0F, 32'hAA22CC44, 32'hAA22CC44);
      vecs[21] = mk(1'b1, 3'd6, 1'b0, 3'd0, 4'h0, 32'h0, 32'h0F0F0F0F, 32'h0F0F0F0F);

      // Reset state.
      reset = 1'b1;
      step();
      step();
      chk("rst_init_done", {31'b0, done1}, 32'h0);
      chk("rst_rdata", rdata1, 32'h0);
      chk("rst_err", {28'b0, err1}, 32'h0);

      // Clear phase with port traffic that must be ignored.
      reset = 1'b0;
      R0_en = 1'b1; R0_addr = 3'd0;
      W0_en = 1'b1; W0_addr = 3'd0; W0_mask = 4'hF; W0_data = 32'hFFFFFFFF;
      wait_init(cyc);
      idle_ports();
      chk("init_cycles", cyc, 32'd8);
      chk("init_done_b0", {31'b0, done0}, 32'h1);
      chk("clear_rd_held", rdata1, 32'h0);

      // Table-driven vectors.
      for (int i = 0; i < NVEC; i++) begin
         R0_en = vecs[i].r_en; R0_addr = vecs[i].r_addr;
         W0_en = vecs[i].w_en; W0_addr = vecs[i].w_addr;
         W0_mask = vecs[i].w_mask; W0_data = vecs[i].w_data;
         step();
         chk($sformatf("vec%0d_b1", i), rdata1, vecs[i].exp1);
         chk($sformatf("vec%0d_b0", i), rdata0, vecs[i].exp0);
         chk($sformatf("vec%0d_err", i), {28'b0, err1}, 32'h0);
      end
      idle_ports();

      // Reset in the middle of the clear sequence.
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (4) step();
      chk("midclr_done", {31'b0, done1}, 32'h0);
      reset = 1'b1;
      step();
      chk("rerst_done", {31'b0, done1}, 32'h0);
      chk("rerst_rdata", rdata1, 32'h0);
      reset = 1'b0;
      wait_init(cyc);
      chk("reinit_cycles", cyc, 32'd8);
      for (int a = 0; a < 8; a++)
         read_chk(3'(a), 32'h0, "postclr");

`ifdef SRAM_PARITY_EN
      // Corrupt one stored bit in granule 2 of entry 1 behind the parity.
      idle_ports();
      W0_en = 1'b1; W0_addr = 3'd1; W0_mask = 4'hF; W0_data = 32'h12345678;
      step();
      idle_ports();
      dut.ram[1][16] = ~dut.ram[1][16];
      R0_en = 1'b1; R0_addr = 3'd1;
      step();
      chk("par_err_flip", {28'b0, err1}, 32'h4);
      chk("par_data_flip", rdata1, 32'h12355678);
      chk("par_err_clean_inst", {28'b0, err0}, 32'h0);
      R0_addr = 3'd3;
      step();
      chk("par_err_unflipped", {28'b0, err1}, 32'h0);
      idle_ports();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
